// File: rtl/ram1p1rwbe_ctrl_pkg.sv
// ram1p1rwbe_ctrl_pkg: shared types and limits for the single-port byte-write SRAM controller
package ram1p1rwbe_ctrl_pkg;
  typedef enum logic {INIT, RUN} state_t;
  localparam int MAX_OUTSTANDING = 3;
  localparam int RSP_DEPTH = 2;
endpackage

// File: rtl/ram1p1rwbe_ctrl_if.sv
// ram1p1rwbe_ctrl_if: request/response stream plus SRAM macro pins
interface ram1p1rwbe_ctrl_if #(parameter int DEPTH = 64, parameter int WIDTH = 128);
  localparam int AW = $clog2(DEPTH);
  logic ReqValid, ReqReady, ReqWrite;
  logic [AW-1:0] ReqAdr;
  logic [WIDTH-1:0] ReqData;
  logic [WIDTH/8-1:0] ReqByteEn;
  logic RspValid, RspReady, InitDone;
  logic [WIDTH-1:0] RspData;
  logic CEB, WEB;
  logic [AW-1:0] A;
  logic [WIDTH-1:0] D, BWEB, Q;
  modport master(output ReqValid, ReqWrite, ReqAdr, ReqData, ReqByteEn, RspReady, Q,
                 input ReqReady, RspValid, RspData, InitDone, CEB, WEB, A, D, BWEB);
  modport slave(input ReqValid, ReqWrite, ReqAdr, ReqData, ReqByteEn, RspReady, Q,
                output ReqReady, RspValid, RspData, InitDone, CEB, WEB, A, D, BWEB);
endinterface

// File: rtl/rsp_fifo2.sv
// rsp_fifo2: two-entry in-order response buffer; push and pop may coincide even when full
module rsp_fifo2 import ram1p1rwbe_ctrl_pkg::*; #(parameter int WIDTH = 128) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem [RSP_DEPTH];
  logic wr_ptr, rd_ptr;
  logic [1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt <= '0;
    end else begin
      if (push) mem[wr_ptr] <= din;
      wr_ptr <= wr_ptr ^ push;
      rd_ptr <= rd_ptr ^ pop;
      cnt <= cnt + 2'(push) - 2'(pop);
    end
  assign dout = mem[rd_ptr];
  assign full = cnt == 2'(RSP_DEPTH);
  assign empty = cnt == 2'd0;
endmodule

// File: rtl/ram1p1rwbe_ctrl.sv
// ram1p1rwbe_ctrl: drives a 1-cycle-latency byte-write SRAM macro from a valid/ready stream,
// buffering read data with backpressure and optionally zero-filling the array after reset.
module ram1p1rwbe_ctrl import ram1p1rwbe_ctrl_pkg::*; #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 128,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input logic clk,
  input logic reset,
  ram1p1rwbe_ctrl_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  state_t state, state_nx;
  logic [AW-1:0] clr_adr;
  logic [1:0] count;
  logic init_done, rd_pend, skid_v, clearing, accept, wr, rd, pop, push, full, empty;
  logic [WIDTH-1:0] skid, din;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= CLEAR_ON_RESET ? INIT : RUN;
      clr_adr <= '0;
      count <= '0;
      init_done <= 1'b0;
      rd_pend <= 1'b0;
      skid_v <= 1'b0;
      skid <= '0;
    end else begin
      state <= state_nx;
      clr_adr <= clr_adr + AW'(state == INIT);
      count <= count + 2'(rd) - 2'(pop);
      init_done <= state_nx == RUN;
      rd_pend <= rd;
      skid_v <= skid_v ? !pop : rd_pend && full && !pop;
      if (rd_pend && full && !pop) skid <= bus.Q;
    end
  // Three outstanding reads can all land while the consumer stalls; the third waits in skid.
  // A full skid implies count==3, so it never coincides with a fresh read return.
  always_comb begin
    state_nx = (state == INIT && clr_adr == AW'(DEPTH - 1)) ? RUN : state;
    clearing = state == INIT && !reset;
    bus.ReqReady = init_done && state == RUN && count < 2'(MAX_OUTSTANDING);
    accept = bus.ReqValid && bus.ReqReady;
    wr = accept && bus.ReqWrite;
    rd = accept && !bus.ReqWrite;
    bus.CEB = !(clearing || accept);
    bus.WEB = !(clearing || wr);
    bus.A = clearing ? clr_adr : init_done ? bus.ReqAdr : '0;
    bus.D = (clearing || !init_done) ? '0 : bus.ReqData;
    for (int i = 0; i < WIDTH / 8; i++)
      bus.BWEB[i*8 +: 8] = {8{!(clearing || (wr && bus.ReqByteEn[i]))}};
    pop = bus.RspValid && bus.RspReady;
    push = skid_v ? pop : rd_pend && (!full || pop);
    din = skid_v ? skid : bus.Q;
  end
  assign bus.RspValid = !empty;
  assign bus.InitDone = init_done;
  rsp_fifo2 #(.WIDTH(WIDTH)) u_fifo (
    .clk(clk), .rst(reset), .push(push), .pop(pop), .din(din),
    .dout(bus.RspData), .full(full), .empty(empty)
  );
endmodule

// File: tb/tb_ram1p1rwbe_ctrl.sv
// tb_ram1p1rwbe_ctrl: scenario tasks against a behavioural SRAM macro and a read-data scoreboard
module tb_ram1p1rwbe_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int vectors = 0;
  int errors = 0;
  int cyc = 0;
  int pops = 0;
  int first_pop = -1;
  int last_pop = -1;
  logic [127:0] macro_mem [64];
  logic [127:0] ref_mem [64];
  logic [127:0] exp_q [$];
  logic s_ceb, s_web;
  logic [127:0] s_bweb;

  ram1p1rwbe_ctrl_if #(.DEPTH(64), .WIDTH(128)) bus();
  ram1p1rwbe_ctrl #(.DEPTH(64), .WIDTH(128), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 64; i++) macro_mem[i] = {$urandom, $urandom, $urandom, $urandom};
    bus.Q = {$urandom, $urandom, $urandom, $urandom};
  end

  always @(posedge clk)
    if (bus.CEB === 1'b0) begin
      if (bus.WEB === 1'b0) macro_mem[bus.A] <= (macro_mem[bus.A] & bus.BWEB) | (bus.D & ~bus.BWEB);
      else bus.Q <= macro_mem[bus.A];
    end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
    $fatal(1);
  end

  task automatic tick(output bit acc);
    logic [127:0] exp;
    @(negedge clk);
    acc = bus.ReqValid && bus.ReqReady;
    s_ceb = bus.CEB;
    s_web = bus.WEB;
    s_bweb = bus.BWEB;
    if (acc) begin
      if (bus.ReqWrite) begin
        for (int b = 0; b < 16; b++)
          if (bus.ReqByteEn[b]) ref_mem[bus.ReqAdr][b*8 +: 8] = bus.ReqData[b*8 +: 8];
      end else exp_q.push_back(ref_mem[bus.ReqAdr]);
    end
    if (bus.RspValid && bus.RspReady) begin
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: got %h, expected no response", bus.RspData);
      end else begin
        exp = exp_q.pop_front();
        if (bus.RspData !== exp) begin
          errors++;
          $display("FAIL rsp_data: got %h, expected %h", bus.RspData, exp);
        end
      end
      pops++;
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit w, input int adr, input logic [127:0] data, input logic [15:0] be);
    bit ok = 1'b0;
    bus.ReqValid = 1'b1;
    bus.ReqWrite = w;
    bus.ReqAdr = 6'(adr);
    bus.ReqData = data;
    bus.ReqByteEn = be;
    for (int k = 0; k < 20 && !ok; k++) tick(ok);
    bus.ReqValid = 1'b0;
    vectors++;
    if (!ok) begin
      errors++;
      $display("FAIL issue_timeout: adr %0d accepted=%0b, expected 1", adr, ok);
    end
  endtask

  task automatic drain();
    bit acc;
    bus.RspReady = 1'b1;
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) tick(acc);
    vectors++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d responses outstanding, expected 0", exp_q.size());
    end
  endtask

  task automatic do_clear();
    reset = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      vectors++;
      if (bus.CEB !== 1'b0 || bus.WEB !== 1'b0 || bus.BWEB !== '0 || bus.A !== 6'(i) ||
          bus.D !== '0 || bus.ReqReady !== 1'b0 || bus.InitDone !== 1'b0) begin
        errors++;
        $display("FAIL clear_cycle %0d: ceb=%b web=%b a=%0d rdy=%b done=%b, expected 0 0 %0d 0 0",
                 i, bus.CEB, bus.WEB, bus.A, bus.ReqReady, bus.InitDone, i);
      end
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    vectors++;
    if (bus.InitDone !== 1'b1 || bus.ReqReady !== 1'b1 || bus.CEB !== 1'b1) begin
      errors++;
      $display("FAIL clear_done: done=%b rdy=%b ceb=%b, expected 1 1 1", bus.InitDone, bus.ReqReady, bus.CEB);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 64; i++) ref_mem[i] = '0;
  endtask

  task automatic test_reset();
    bus.ReqValid = 1'b1;
    bus.ReqWrite = 1'b1;
    bus.ReqAdr = 6'd5;
    bus.ReqData = {4{32'hDEADBEEF}};
    bus.ReqByteEn = 16'hFFFF;
    bus.RspReady = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (bus.ReqReady !== 1'b0 || bus.RspValid !== 1'b0 || bus.InitDone !== 1'b0 || bus.RspData !== '0) begin
      errors++;
      $display("FAIL reset_stream: rdy=%b rv=%b done=%b data=%h, expected 0 0 0 0",
               bus.ReqReady, bus.RspValid, bus.InitDone, bus.RspData);
    end
    vectors++;
    if (bus.CEB !== 1'b1 || bus.WEB !== 1'b1 || bus.A !== '0 || bus.D !== '0 || bus.BWEB !== '1) begin
      errors++;
      $display("FAIL reset_macro: ceb=%b web=%b a=%0d d=%h bweb=%h, expected 1 1 0 0 all-ones",
               bus.CEB, bus.WEB, bus.A, bus.D, bus.BWEB);
    end
    bus.ReqValid = 1'b0;
    do_clear();
  endtask

  task automatic test_clear_reads();
    issue(1'b0, 0, '0, '0);
    issue(1'b0, 31, '0, '0);
    issue(1'b0, 63, '0, '0);
    drain();
  endtask

  task automatic test_byte_write();
    bit acc;
    bus.RspReady = 1'b1;
    issue(1'b1, 5, {16{8'hFF}}, 16'hFFFF);
    issue(1'b1, 5, {16{8'h11}}, 16'h0001);
    issue(1'b0, 5, '0, '0);
    vectors++;
    if (bus.RspValid !== 1'b0) begin
      errors++;
      $display("FAIL byte_latency_n1: RspValid=%b, expected 0", bus.RspValid);
    end
    tick(acc);
    vectors++;
    if (bus.RspValid !== 1'b1 || bus.RspData !== {{15{8'hFF}}, 8'h11}) begin
      errors++;
      $display("FAIL byte_latency_n2: rv=%b data=%h, expected 1 %h", bus.RspValid, bus.RspData, {{15{8'hFF}}, 8'h11});
    end
    drain();
    issue(1'b1, 7, {16{8'hAB}}, 16'h0000);
    vectors++;
    if (s_ceb !== 1'b0 || s_web !== 1'b0 || s_bweb !== '1) begin
      errors++;
      $display("FAIL be_zero_strobes: ceb=%b web=%b bweb=%h, expected 0 0 all-ones", s_ceb, s_web, s_bweb);
    end
    issue(1'b1, 9, {8{16'h1234}}, 16'hFFFF);
    issue(1'b0, 9, '0, '0);
    issue(1'b0, 7, '0, '0);
    drain();
  endtask

  task automatic test_backpressure();
    bit acc;
    for (int k = 0; k < 4; k++) issue(1'b1, 10 + k, {4{32'(k + 100)}}, 16'hFFFF);
    bus.RspReady = 1'b0;
    bus.ReqValid = 1'b1;
    bus.ReqWrite = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.ReqAdr = 6'(10 + k);
      tick(acc);
      vectors++;
      if (acc !== 1'b1) begin
        errors++;
        $display("FAIL bp_accept %0d: accepted=%b, expected 1", k, acc);
      end
    end
    bus.ReqAdr = 6'd13;
    for (int k = 0; k < 3; k++) begin
      tick(acc);
      vectors++;
      if (acc !== 1'b0) begin
        errors++;
        $display("FAIL bp_block %0d: accepted=%b, expected 0", k, acc);
      end
    end
    vectors++;
    if (bus.RspValid !== 1'b1) begin
      errors++;
      $display("FAIL bp_rsp_valid: RspValid=%b, expected 1", bus.RspValid);
    end
    bus.RspReady = 1'b1;
    tick(acc);
    vectors++;
    if (acc !== 1'b0) begin
      errors++;
      $display("FAIL bp_pop_cycle: accepted=%b, expected 0", acc);
    end
    tick(acc);
    vectors++;
    if (acc !== 1'b1) begin
      errors++;
      $display("FAIL bp_resume: accepted=%b, expected 1", acc);
    end
    bus.ReqValid = 1'b0;
    drain();
  endtask

  task automatic test_back_to_back();
    bit acc;
    int n = 0;
    bus.RspReady = 1'b1;
    pops = 0;
    first_pop = -1;
    bus.ReqValid = 1'b1;
    bus.ReqWrite = 1'b0;
    for (int k = 0; k < 16; k++) begin
      bus.ReqAdr = 6'(k);
      tick(acc);
      if (acc) n++;
    end
    bus.ReqValid = 1'b0;
    vectors++;
    if (n != 16) begin
      errors++;
      $display("FAIL b2b_accepts: got %0d in 16 cycles, expected 16", n);
    end
    drain();
    vectors++;
    if (pops != 16 || last_pop - first_pop != 15) begin
      errors++;
      $display("FAIL b2b_bubbles: pops=%0d span=%0d, expected 16 15", pops, last_pop - first_pop);
    end
  endtask

  task automatic test_reset_mid_init();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #3;
    vectors++;
    if (bus.A !== 6'd20 || bus.CEB !== 1'b0) begin
      errors++;
      $display("FAIL mid_init_pre: a=%0d ceb=%b, expected 20 0", bus.A, bus.CEB);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (bus.CEB !== 1'b1 || bus.WEB !== 1'b1 || bus.A !== '0 || bus.BWEB !== '1 || bus.D !== '0 ||
        bus.InitDone !== 1'b0 || bus.ReqReady !== 1'b0) begin
      errors++;
      $display("FAIL mid_init_async: ceb=%b web=%b a=%0d done=%b rdy=%b, expected 1 1 0 0 0",
               bus.CEB, bus.WEB, bus.A, bus.InitDone, bus.ReqReady);
    end
    @(posedge clk);
    #1;
    do_clear();
  endtask

  task automatic test_reset_buffered();
    bit acc;
    int n = 0;
    issue(1'b1, 40, {4{32'hCAFE0040}}, 16'hFFFF);
    issue(1'b1, 41, {4{32'hCAFE0041}}, 16'hFFFF);
    bus.RspReady = 1'b0;
    issue(1'b0, 40, '0, '0);
    issue(1'b0, 41, '0, '0);
    tick(acc);
    tick(acc);
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if (bus.RspValid !== 1'b0 || bus.RspData !== '0) begin
      errors++;
      $display("FAIL buf_reset_async: rv=%b data=%h, expected 0 0", bus.RspValid, bus.RspData);
    end
    exp_q.delete();
    @(posedge clk);
    #1;
    do_clear();
    tick(acc);
    vectors++;
    if (bus.RspValid !== 1'b0) begin
      errors++;
      $display("FAIL buf_no_stale: RspValid=%b, expected 0", bus.RspValid);
    end
    bus.ReqValid = 1'b1;
    bus.ReqWrite = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.ReqAdr = 6'(40 + k);
      tick(acc);
      if (acc) n++;
    end
    bus.ReqValid = 1'b0;
    vectors++;
    if (n != 3) begin
      errors++;
      $display("FAIL buf_count_cleared: accepted %0d reads while stalled, expected 3", n);
    end
    drain();
  endtask

  initial begin
    bus.ReqValid = 1'b0;
    bus.ReqWrite = 1'b0;
    bus.ReqAdr = '0;
    bus.ReqData = '0;
    bus.ReqByteEn = '0;
    bus.RspReady = 1'b0;
    test_reset();
    test_clear_reads();
    test_byte_write();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_init();
    test_reset_buffered();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
